// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: accepts one request, waits LATENCY
// cycles in BUSY, performs a single word access, then pulses ack for one cycle.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [32:0]   LIMIT    = 33'(4 * DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          bad;
  logic [AW-1:0] idx;
  logic          do_access;

  // Error is judged on the captured address, never on the live bus.
  assign bad       = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= LIMIT);
  assign idx       = addr_q[AW+1:2];
  assign do_access = (state == BUSY) && (cnt == '0);

  assign ready_o = (state == IDLE);
  assign stall_o = req_i & ~ack_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RESP;
            ack_o <= 1'b1;
            err_o <= bad;
            if (!we_q) rdata_o <= bad ? 32'h0 : mem[idx];
          end
        end
        RESP: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage is never cleared; an async reset drops state to IDLE, which kills do_access.
  always_ff @(posedge clk_i) begin
    if (rst_i && do_access && we_q && !bad) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=4 instance for the main
// sequence and a LATENCY=1 instance for the short-latency case.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, ack, err, stall;
  logic [31:0] rdata;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ready1, ack1, err1, stall1;
  logic [31:0] rdata1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .ack_o(ack), .rdata_o(rdata), .err_o(err), .stall_o(stall)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .ready_o(ready1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=4 instance; checks latency, err, rdata and ack width.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic e_err, input logic chk_rd, input logic [31:0] e_rd,
                      input string tag);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    chk(ready, 1, {tag, ".ready"});
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 20);
    chk(n, 4, {tag, ".latency"});
    chk(ack, 1, {tag, ".ack"});
    chk(err, e_err, {tag, ".err"});
    if (chk_rd) chk(rdata, e_rd, {tag, ".rdata"});
    chk(stall, 0, {tag, ".stall_ack"});
    req = 1'b0;
    @(posedge clk); #1;
    chk(ack, 0, {tag, ".ack_drop"});
    chk(err, 0, {tag, ".err_drop"});
  endtask

  initial begin
    int seen, first, second, hits;

    #12;
    chk(ready, 1, "rst.ready");
    chk(ack, 0, "rst.ack");
    chk(err, 0, "rst.err");
    chk(rdata, 0, "rst.rdata");
    chk(stall, 0, "rst.stall");
    #10 rst = 1'b1;

    // 1: store then load back
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, "t1.store");
    xfer(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, "t1.load");

    // 2: misaligned load zeroes rdata, storage untouched
    xfer(1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0, "t2.misalign");
    xfer(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, "t2.reload");

    // 3: out-of-range store must not alias onto word 0
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 32'hDEADBEEF, "t3.store0");
    xfer(1'b1, 32'h400, 32'h12345678, 1'b1, 1'b1, 32'hDEADBEEF, "t3.oor");
    xfer(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, "t3.load0");

    // 4: reset mid-BUSY aborts the store
    xfer(1'b1, 32'h20, 32'h11112222, 1'b0, 1'b0, 32'h0, "t4.pre");
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55AA55AA;
    @(posedge clk);
    @(posedge clk); #1;
    chk(ready, 0, "t4.busy");
    #2 rst = 1'b0;
    #1;
    chk(ready, 1, "t4.rst_ready");
    chk(ack, 0, "t4.rst_ack");
    req = 1'b0;
    #3 rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) hits++;
    end
    chk(hits, 0, "t4.no_ack");
    chk(ready, 1, "t4.idle");
    xfer(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h11112222, "t4.load");

    // 5: back-to-back loads with req held high
    xfer(1'b1, 32'h04, 32'hA0A0A0A4, 1'b0, 1'b0, 32'h0, "t5.st4");
    xfer(1'b1, 32'h08, 32'hB0B0B0B8, 1'b0, 1'b0, 32'h0, "t5.st8");
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h04;
    seen = 0; first = -1; second = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (req) chk(stall, !ack, "t5.stall");
      if (ack) begin
        if (seen == 0) begin
          first = i;
          chk(rdata, 32'hA0A0A0A4, "t5.rd4");
          addr = 32'h08;
        end else begin
          second = i;
          chk(rdata, 32'hB0B0B0B8, "t5.rd8");
          req = 1'b0;
        end
        seen++;
      end
    end
    chk(first, 4, "t5.first_ack");
    chk(second, 10, "t5.second_ack");
    chk(seen, 2, "t5.ack_count");

    // 6: LATENCY=1 instance, req dropped one cycle after accept
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h0F0F0F0F;
    @(posedge clk); #1;
    chk(ack1, 0, "t6.st_e0");
    @(negedge clk); req1 = 1'b0;
    @(posedge clk); #1;
    chk(ack1, 1, "t6.st_ack");
    chk(err1, 0, "t6.st_err");
    chk(stall1, 0, "t6.st_stall");
    @(posedge clk); #1;
    chk(ack1, 0, "t6.st_drop");
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0;
    @(posedge clk); #1;
    chk(ack1, 0, "t6.ld_e0");
    @(negedge clk); req1 = 1'b0;
    @(posedge clk); #1;
    chk(ack1, 1, "t6.ld_ack");
    chk(rdata1, 32'h0F0F0F0F, "t6.ld_rdata");
    @(posedge clk); #1;
    chk(ack1, 0, "t6.ld_drop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
